// File: rtl/serial_pkg.sv
// serial_pkg: shared receiver state type and STATUS register bit positions.
package serial_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;
    localparam int STAT_NONEMPTY = 0;
    localparam int STAT_FULL     = 1;
    localparam int STAT_FERR     = 2;
    localparam int STAT_OVR      = 3;
    localparam int STAT_PERR     = 4;
    localparam int OVERSAMPLE    = 16;
endpackage

// File: rtl/serial_rx_fifo.sv
// serial_rx_fifo: power-of-two FIFO with occupancy count; a pop while full lets a same-cycle push in.
module serial_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    clrn,
    input  logic                    push,
    input  logic [WIDTH-1:0]        din,
    input  logic                    pop,
    output logic [WIDTH-1:0]        dout,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr, rd;
    logic do_pop, do_push;
    always_comb begin
        empty   = count == '0;
        full    = count == (AW+1)'(DEPTH);
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        dout    = empty ? '0 : mem[rd];
    end
    always_ff @(posedge clk)
        if (do_push) mem[wr] <= din;
    always_ff @(posedge clk or negedge clrn)
        if (!clrn) begin
            wr    <= '0;
            rd    <= '0;
            count <= '0;
        end else begin
            if (do_push) wr <= wr + 1'b1;
            if (do_pop) rd <= rd + 1'b1;
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
endmodule

// File: rtl/serial_rx.sv
// serial_rx: memory-mapped UART receiver, 16x oversampled 8N1 into a byte FIFO.
// Define SERIAL_RX_PARITY_EN for 8E1 frames with a sticky parity-error flag.
module serial_rx
    import serial_pkg::*;
#(
    parameter int CLK_HZ = 10_000_000,
    parameter int BAUD   = 9600,
    parameter int DEPTH  = 16
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        rxd,
    input  logic        en,
    input  logic [31:0] addr,
    output logic [31:0] dout,
    output logic        rx_busy
);
    localparam int DIV = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int CW  = DIV > 1 ? $clog2(DIV) : 1;
    localparam int AW  = $clog2(DEPTH);
`ifdef SERIAL_RX_PARITY_EN
    localparam rx_state_t AFTER_DATA = PARITY;
`else
    localparam rx_state_t AFTER_DATA = STOP;
`endif
    rx_state_t state, nxt;
    logic meta, rs;
    logic [CW-1:0] div_cnt;
    logic tick, at_mid, at_end;
    logic [3:0] tc;
    logic [2:0] bi;
    logic [7:0] shift;
    logic push_byte, set_ferr, set_ovr, set_perr, pbad;
    logic ferr, ovr, perr;
    logic pop_fire, clr;
    logic [7:0] head;
    logic [AW:0] count;
    logic full, empty;
    logic [3:0] cnt_sat;
    logic [31:0] stat;
    logic unused_addr;
    assign unused_addr = ^{addr[31:3], addr[1:0]};
    always_ff @(posedge clk or negedge clrn)
        if (!clrn) {meta, rs} <= 2'b11;
        else {meta, rs} <= {rxd, meta};
    // Held at zero while idle so tick phase is set by the start edge.
    assign tick   = div_cnt == CW'(DIV - 1);
    assign at_mid = tick && tc == 4'd7;
    assign at_end = tick && tc == 4'd15;
    always_ff @(posedge clk or negedge clrn)
        if (!clrn) div_cnt <= '0;
        else div_cnt <= (state == IDLE || tick) ? '0 : div_cnt + 1'b1;
    always_ff @(posedge clk or negedge clrn)
        if (!clrn) state <= IDLE;
        else state <= nxt;
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = rs ? IDLE : START;
            START:   nxt = at_mid ? (rs ? IDLE : DATA) : START;
            DATA:    nxt = (at_end && bi == 3'd7) ? AFTER_DATA : DATA;
            PARITY:  nxt = at_end ? STOP : PARITY;
            STOP:    nxt = at_end ? IDLE : STOP;
            default: nxt = IDLE;
        endcase
    end
    always_comb begin
        rx_busy   = state != IDLE;
        push_byte = state == STOP && at_end && rs && !pbad;
        set_ferr  = state == STOP && at_end && !rs;
`ifdef SERIAL_RX_PARITY_EN
        set_perr  = state == PARITY && at_end && (^shift ^ rs);
`else
        set_perr  = 1'b0;
`endif
    end
    always_ff @(posedge clk or negedge clrn)
        if (!clrn) begin
            tc    <= '0;
            bi    <= '0;
            shift <= '0;
        end else begin
            tc <= (state == IDLE || (state == START && at_mid)) ? 4'd0 : tc + 4'(tick);
            if (state == START) bi <= '0;
            else if (state == DATA && at_end) bi <= bi + 1'b1;
            if (state == DATA && at_end) shift[bi] <= rs;
        end
`ifdef SERIAL_RX_PARITY_EN
    always_ff @(posedge clk or negedge clrn)
        if (!clrn) pbad <= 1'b0;
        else if (state == START) pbad <= 1'b0;
        else if (set_perr) pbad <= 1'b1;
`else
    assign pbad = 1'b0;
`endif
    assign pop_fire = en && !addr[2] && !empty;
    assign clr      = en && addr[2];
    assign set_ovr  = push_byte && full && !pop_fire;
    serial_rx_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
        .clk(clk),
        .clrn(clrn),
        .push(push_byte),
        .din(shift),
        .pop(pop_fire),
        .dout(head),
        .count(count),
        .full(full),
        .empty(empty)
    );
    // A flag event in the same cycle as a STATUS read survives the clear.
    always_ff @(posedge clk or negedge clrn)
        if (!clrn) begin
            ferr <= 1'b0;
            ovr  <= 1'b0;
            perr <= 1'b0;
        end else begin
            ferr <= set_ferr | (ferr & !clr);
            ovr  <= set_ovr | (ovr & !clr);
            perr <= set_perr | (perr & !clr);
        end
    always_comb begin
        cnt_sat             = int'(count) > 15 ? 4'd15 : 4'(count);
        stat                = '0;
        stat[STAT_NONEMPTY] = !empty;
        stat[STAT_FULL]     = full;
        stat[STAT_FERR]     = ferr;
        stat[STAT_OVR]      = ovr;
`ifdef SERIAL_RX_PARITY_EN
        // perr owns bit 4 here, so the count field moves up one place.
        stat[STAT_PERR]     = perr;
        stat[8:5]           = cnt_sat;
`else
        stat[7:4]           = cnt_sat;
`endif
        dout = addr[2] ? stat : {23'b0, !empty, head};
    end
endmodule
